// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two writeback requesters (A: ALU, B: load return) onto the register-file write port.
// Build option: define WB_ARB_RR_EN for round-robin between contending ports; default is fixed A-over-B priority.
module regfile_wb_arbiter #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid_i,
  input  logic [4:0]        a_rd_i,
  input  logic [DWIDTH-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [4:0]        b_rd_i,
  input  logic [DWIDTH-1:0] b_data_i,
  output logic              b_ready_o,
  output logic [4:0]        rd_o,
  output logic [DWIDTH-1:0] datawb_o,
  output logic              regwren_o,
  output logic              busy_o
);

  localparam int unsigned RW = 5;
  localparam int unsigned NP = 2;
  localparam int unsigned CW = 2;
  localparam int unsigned DEPTH = 2;

  logic [NP-1:0]     in_valid;
  logic [RW-1:0]     in_rd   [NP];
  logic [DWIDTH-1:0] in_data [NP];

  logic [RW-1:0]     mem_rd   [NP][DEPTH];
  logic [DWIDTH-1:0] mem_data [NP][DEPTH];
  logic              wptr [NP];
  logic              rptr [NP];
  logic [CW-1:0]     cnt  [NP];

  logic [NP-1:0]     full;
  logic [NP-1:0]     nonempty;
  logic [NP-1:0]     push;
  logic [NP-1:0]     pop;
  logic [RW-1:0]     head_rd   [NP];
  logic [DWIDTH-1:0] head_data [NP];
  logic              gnt_a;
  logic              gnt_b;
  logic [RW-1:0]     sel_rd;
  logic [DWIDTH-1:0] sel_data;

  // Port 0 is A, port 1 is B.
  always_comb begin
    in_valid   = {b_valid_i, a_valid_i};
    in_rd[0]   = a_rd_i;
    in_rd[1]   = b_rd_i;
    in_data[0] = a_data_i;
    in_data[1] = b_data_i;
  end

  // Ready depends only on registered occupancy, so a full FIFO refuses even while popping.
  always_comb begin
    full     = '0;
    nonempty = '0;
    push     = '0;
    for (int p = 0; p < NP; p++) begin
      full[p]      = (cnt[p] == CW'(DEPTH));
      nonempty[p]  = (cnt[p] != '0);
      push[p]      = in_valid[p] && !full[p];
      head_rd[p]   = mem_rd[p][rptr[p]];
      head_data[p] = mem_data[p][rptr[p]];
    end
  end

`ifdef WB_ARB_RR_EN
  // last_b set means B takes the next contended slot; reset 0 hands A the first one.
  logic last_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_b <= 1'b0;
    end else if (&nonempty) begin
      last_b <= !last_b;
    end
  end

  always_comb begin
    gnt_b = nonempty[1] && (!nonempty[0] || last_b);
    gnt_a = nonempty[0] && !gnt_b;
  end
`else
  always_comb begin
    gnt_a = nonempty[0];
    gnt_b = nonempty[1] && !nonempty[0];
  end
`endif

  always_comb begin
    pop      = {gnt_b, gnt_a};
    sel_rd   = gnt_b ? head_rd[1]   : head_rd[0];
    sel_data = gnt_b ? head_data[1] : head_data[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        wptr[p] <= 1'b0;
        rptr[p] <= 1'b0;
        cnt[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (push[p]) wptr[p] <= !wptr[p];
        if (pop[p])  rptr[p] <= !rptr[p];
        cnt[p] <= cnt[p] + CW'(push[p]) - CW'(pop[p]);
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (push[p]) begin
        mem_rd[p][wptr[p]]   <= in_rd[p];
        mem_data[p][wptr[p]] <= in_data[p];
      end
    end
  end

  // rd==0 entries still load the bus but never assert the write enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_o      <= '0;
      datawb_o  <= '0;
      regwren_o <= 1'b0;
    end else if (gnt_a || gnt_b) begin
      rd_o      <= sel_rd;
      datawb_o  <= sel_data;
      regwren_o <= (sel_rd != '0);
    end else begin
      regwren_o <= 1'b0;
    end
  end

  assign a_ready_o = !full[0];
  assign b_ready_o = !full[1];
  assign busy_o    = (|nonempty) || regwren_o;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid_i;
  logic [4:0]  a_rd_i;
  logic [31:0] a_data_i;
  logic        a_ready_o;
  logic        b_valid_i;
  logic [4:0]  b_rd_i;
  logic [31:0] b_data_i;
  logic        b_ready_o;
  logic [4:0]  rd_o;
  logic [31:0] datawb_o;
  logic        regwren_o;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_wb_arbiter #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid_i(a_valid_i), .a_rd_i(a_rd_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
    .b_valid_i(b_valid_i), .b_rd_i(b_rd_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
    .rd_o(rd_o), .datawb_o(datawb_o), .regwren_o(regwren_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-port queues of accepted writes, drained one per edge.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        qa[$];
  ent_t        qb[$];
  bit          m_b_turn;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  bit          exp_wren;

  task automatic model_clear();
    qa.delete();
    qb.delete();
    m_b_turn = 1'b0;
    exp_rd   = '0;
    exp_data = '0;
    exp_wren = 1'b0;
  endtask

  // Drive inputs for one edge, advance the model, return at edge + 1.
  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit bv, input logic [4:0] brd, input logic [31:0] bd,
                      output bit acc_a, output bit acc_b);
    int   w;
    ent_t e;
    a_valid_i = av; a_rd_i = ard; a_data_i = ad;
    b_valid_i = bv; b_rd_i = brd; b_data_i = bd;
    acc_a = av && (qa.size() < 2);
    acc_b = bv && (qb.size() < 2);
    @(posedge clk);
    #1;
    w = 0;
    if (qa.size() > 0 && qb.size() > 0) begin
`ifdef WB_ARB_RR_EN
      w = m_b_turn ? 2 : 1;
      m_b_turn = !m_b_turn;
`else
      w = 1;
`endif
    end else if (qa.size() > 0) begin
      w = 1;
    end else if (qb.size() > 0) begin
      w = 2;
    end
    exp_wren = 1'b0;
    e = '0;
    if (w == 1) e = qa.pop_front();
    if (w == 2) e = qb.pop_front();
    if (w != 0) begin
      exp_rd   = e.rd;
      exp_data = e.data;
      exp_wren = (e.rd != 5'd0);
    end
    if (acc_a) qa.push_back(ent_t'({ard, ad}));
    if (acc_b) qb.push_back(ent_t'({brd, bd}));
  endtask

  task automatic do_reset();
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (rd_o !== 5'd0 || datawb_o !== 32'd0 || regwren_o !== 1'b0 || busy_o !== 1'b0 ||
        a_ready_o !== 1'b1 || b_ready_o !== 1'b1)
      $display("FAIL reset_state: rd=%0d data=%h wren=%b busy=%b ardy=%b brdy=%b, want 0 0 0 0 1 1",
               rd_o, datawb_o, regwren_o, busy_o, a_ready_o, b_ready_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid_traffic();
    bit xa, xb;
    do_reset();
    step(1, 5'd7, 32'h7777, 1, 5'd8, 32'h8888, xa, xb);
    step(1, 5'd17, 32'h1717, 1, 5'd18, 32'h1818, xa, xb);
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL pre_reset_busy: busy=%b want 1", busy_o);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (regwren_o !== 1'b0 || busy_o !== 1'b0 || rd_o !== 5'd0 || datawb_o !== 32'd0)
      $display("FAIL async_reset: wren=%b busy=%b rd=%0d data=%h want 0 0 0 0",
               regwren_o, busy_o, rd_o, datawb_o);
    else n_pass++;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
    n_checks++;
    if (a_ready_o !== 1'b1 || b_ready_o !== 1'b1)
      $display("FAIL ready_after_reset: ardy=%b brdy=%b want 1 1", a_ready_o, b_ready_o);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, xa, xb);
      n_checks++;
      if (regwren_o !== 1'b0 || busy_o !== 1'b0)
        $display("FAIL stale_write cyc%0d: wren=%b busy=%b want 0 0", i, regwren_o, busy_o);
      else n_pass++;
    end
  endtask

  task automatic test_single_write();
    bit xa, xb;
    do_reset();
    step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, xa, xb);
    n_checks++;
    if (regwren_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL single_k: wren=%b busy=%b want 0 1", regwren_o, busy_o);
    else n_pass++;
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, xa, xb);
    n_checks++;
    if (regwren_o !== 1'b1 || rd_o !== 5'd5 || datawb_o !== 32'hDEADBEEF)
      $display("FAIL single_k1: wren=%b rd=%0d data=%h want 1 5 deadbeef", regwren_o, rd_o, datawb_o);
    else n_pass++;
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, xa, xb);
    n_checks++;
    if (regwren_o !== 1'b0 || busy_o !== 1'b0 || rd_o !== 5'd5 || datawb_o !== 32'hDEADBEEF)
      $display("FAIL single_k2: wren=%b busy=%b rd=%0d data=%h want 0 0 5 deadbeef",
               regwren_o, busy_o, rd_o, datawb_o);
    else n_pass++;
  endtask

  task automatic test_x0_drop();
    bit xa, xb;
    do_reset();
    step(1, 5'd0, 32'h12345678, 0, 5'd0, 32'd0, xa, xb);
    n_checks++;
    if (a_ready_o !== 1'b1) $display("FAIL x0_ready: ardy=%b want 1", a_ready_o);
    else n_pass++;
    step(1, 5'd9, 32'h99990009, 0, 5'd0, 32'd0, xa, xb);
    n_checks++;
    if (regwren_o !== 1'b0 || a_ready_o !== 1'b1)
      $display("FAIL x0_slot: wren=%b ardy=%b want 0 1", regwren_o, a_ready_o);
    else n_pass++;
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, xa, xb);
    n_checks++;
    if (regwren_o !== 1'b1 || rd_o !== 5'd9 || datawb_o !== 32'h99990009)
      $display("FAIL x0_next: wren=%b rd=%0d data=%h want 1 9 99990009", regwren_o, rd_o, datawb_o);
    else n_pass++;
  endtask

  task automatic test_contention();
    int   exp_order[6];
    int   got_rd[$];
    logic [31:0] got_data[$];
    int   ia, ib;
    bit   aa, ab;
    logic [4:0] ra, rb;
`ifdef WB_ARB_RR_EN
    exp_order = '{1, 4, 2, 5, 3, 6};
`else
    exp_order = '{1, 2, 3, 4, 5, 6};
`endif
    do_reset();
    ia = 0;
    ib = 0;
    for (int c = 0; c < 20; c++) begin
      ra = 5'(1 + ia);
      rb = 5'(4 + ib);
      step(ia < 3, ra, 32'hA0000000 | 32'(ra), ib < 3, rb, 32'hB0000000 | 32'(rb), aa, ab);
      if (aa) ia++;
      if (ab) ib++;
      if (regwren_o === 1'b1) begin
        got_rd.push_back(int'(rd_o));
        got_data.push_back(datawb_o);
      end
    end
    n_checks++;
    if (got_rd.size() != 6) $display("FAIL contention_count: got %0d writes want 6", got_rd.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < got_rd.size(); i++) begin
      n_checks++;
      if (got_rd[i] != exp_order[i] ||
          got_data[i] !== (((exp_order[i] < 4) ? 32'hA0000000 : 32'hB0000000) | 32'(exp_order[i])))
        $display("FAIL contention_order[%0d]: rd=%0d data=%h want rd=%0d", i, got_rd[i], got_data[i], exp_order[i]);
      else n_pass++;
    end
  endtask

  task automatic test_full_fifo();
    int  ia, ib;
    int  got_a[$];
    int  got_b[$];
    bit  aa, ab;
    bit  saw_full;
    logic [4:0] ra, rb;
    do_reset();
    ia = 0;
    ib = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 40; c++) begin
      ra = 5'(10 + ia);
      rb = 5'(20 + ib);
      step(ia < 6, ra, 32'(ra), ib < 3, rb, 32'(rb), aa, ab);
      if (aa) ia++;
      if (ab) begin
        ib++;
        if (ib == 2) begin
          saw_full = 1'b1;
          n_checks++;
          if (b_ready_o !== 1'b0) $display("FAIL full_ready: brdy=%b want 0 after 2 pushes", b_ready_o);
          else n_pass++;
        end
      end
      n_checks++;
      if (b_ready_o !== (qb.size() < 2) || a_ready_o !== (qa.size() < 2))
        $display("FAIL full_ready_trace c%0d: ardy=%b brdy=%b want %b %b",
                 c, a_ready_o, b_ready_o, qa.size() < 2, qb.size() < 2);
      else n_pass++;
      if (regwren_o === 1'b1) begin
        if (rd_o >= 5'd20) got_b.push_back(int'(rd_o));
        else got_a.push_back(int'(rd_o));
      end
    end
    n_checks++;
    if (!saw_full || ib != 3 || got_a.size() != 6 || got_b.size() != 3)
      $display("FAIL full_done: b_accepts=%0d a_writes=%0d b_writes=%0d want 3 6 3",
               ib, got_a.size(), got_b.size());
    else n_pass++;
    for (int i = 0; i < got_b.size() && i < 3; i++) begin
      n_checks++;
      if (got_b[i] != 20 + i) $display("FAIL full_b_order[%0d]: rd=%0d want %0d", i, got_b[i], 20 + i);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit pa, pb, aa, ab, exp_busy;
    logic [4:0]  ra, rb;
    logic [31:0] da, db;
    do_reset();
    pa = 0; pb = 0; ra = '0; rb = '0; da = '0; db = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pa && $urandom_range(0, 99) < 60) begin
        pa = 1; ra = 5'($urandom_range(0, 31)); da = $urandom;
      end
      if (!pb && $urandom_range(0, 99) < 50) begin
        pb = 1; rb = 5'($urandom_range(0, 31)); db = $urandom;
      end
      step(pa, ra, da, pb, rb, db, aa, ab);
      if (aa) pa = 0;
      if (ab) pb = 0;
      exp_busy = (qa.size() > 0) || (qb.size() > 0) || exp_wren;
      n_checks++;
      if (regwren_o !== exp_wren || rd_o !== exp_rd || datawb_o !== exp_data ||
          a_ready_o !== (qa.size() < 2) || b_ready_o !== (qb.size() < 2) || busy_o !== exp_busy)
        $display("FAIL random c%0d: wren=%b rd=%0d data=%h ardy=%b brdy=%b busy=%b want %b %0d %h %b %b %b",
                 c, regwren_o, rd_o, datawb_o, a_ready_o, b_ready_o, busy_o,
                 exp_wren, exp_rd, exp_data, qa.size() < 2, qb.size() < 2, exp_busy);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b0;
    a_valid_i = 1'b0; a_rd_i = '0; a_data_i = '0;
    b_valid_i = 1'b0; b_rd_i = '0; b_data_i = '0;
    model_clear();
    test_reset();
    test_single_write();
    test_x0_drop();
    test_contention();
    test_full_fifo();
    test_reset_mid_traffic();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
